// File: rtl/ingr_spis_avmm_router.sv
// Routes SPI-bridge Avalon accesses to the ingress buffer or to a small local CSR block.
// Drops and counts malformed accesses, and bounds forwarded-read latency with a timeout.
module ingr_spis_avmm_router #(
   parameter int          INGR_SLV_ADDR_WIDTH = 9,
   parameter int          INGR_SLV_CSR_AWIDTH = 8,
   parameter int          RD_TIMEOUT          = 1023,
   parameter logic [31:0] ID_VALUE            = 32'h4953_5231
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [31:0]                    s_addr,
   input  logic                           s_write,
   input  logic                           s_read,
   input  logic [3:0]                     s_byteen,
   input  logic [31:0]                    s_wrdata,
   output logic [31:0]                    s_rddata,
   output logic                           s_rdvld,
   output logic                           s_waitreq,
   output logic [INGR_SLV_ADDR_WIDTH-1:0] m_addr,
   output logic                           m_write,
   output logic                           m_read,
   output logic [31:0]                    m_wrdata,
   input  logic [31:0]                    m_rddata,
   input  logic                           m_rddvld,
   input  logic                           m_waitreq,
   output logic                           err_cnt_nz
);

   localparam int TW = $clog2(RD_TIMEOUT + 1);
   localparam int CW = INGR_SLV_CSR_AWIDTH - 2;
   localparam logic [TW-1:0] TMO_LOAD = TW'(RD_TIMEOUT);
   localparam logic [TW-1:0] TMO_LAST = TW'(1);
   localparam logic [CW-1:0] CSR_ID     = CW'(0);
   localparam logic [CW-1:0] CSR_STATUS = CW'(1);
   localparam logic [CW-1:0] CSR_LAST   = CW'(2);
   localparam logic [CW-1:0] CSR_CTRL   = CW'(3);

   typedef enum logic [1:0] {ST_IDLE, ST_RD_WAIT, ST_LOCAL_RSP} state_t;

   state_t        r_state;
   logic [TW-1:0] r_timer;
   logic          r_rdvld;
   logic [31:0]   r_rddata;
   logic [15:0]   r_err_cnt;
   logic [15:0]   r_tmo_cnt;
   logic [31:0]   r_last_err;
   logic          r_fwd_en;
   logic          r_err_cnt_nz;

   logic          w_idle;
   logic          w_cmd;
   logic          w_local;
   logic          w_fwd;
   logic          w_err;
   logic [CW-1:0] w_csr_word;
   logic [31:0]   w_csr_rdata;
   logic          w_fwd_rd_acc;
   logic          w_err_acc;
   logic          w_local_wr;
   logic          w_ctrl_wr;
   logic          w_clr;
   logic          w_timeout;
   logic          w_buf_rsp;

   assign w_idle       = (r_state == ST_IDLE);
   assign w_cmd        = s_read | s_write;
   assign w_local      = (s_addr[31:INGR_SLV_CSR_AWIDTH] == '0);
   assign w_fwd        = !w_local && (s_byteen == 4'hF) && r_fwd_en;
   assign w_err        = !w_local && !w_fwd;
   assign w_csr_word   = s_addr[INGR_SLV_CSR_AWIDTH-1:2];
   assign w_fwd_rd_acc = w_idle && w_fwd && s_read && !m_waitreq;
   assign w_err_acc    = w_idle && w_err && w_cmd;
   assign w_local_wr   = w_idle && w_local && s_write && (s_byteen == 4'hF);
   assign w_ctrl_wr    = w_local_wr && (w_csr_word == CSR_CTRL);
   assign w_clr        = w_ctrl_wr && s_wrdata[0];
   assign w_buf_rsp    = (r_state == ST_RD_WAIT) && m_rddvld;
   // r_timer holds the RD_WAIT cycles still allowed, so expiry lands RD_TIMEOUT+1 after acceptance
   assign w_timeout    = (r_state == ST_RD_WAIT) && !m_rddvld && (r_timer == TMO_LAST);

   always_comb begin
      w_csr_rdata = '0;
      case (w_csr_word)
         CSR_ID:     w_csr_rdata = ID_VALUE;
         CSR_STATUS: w_csr_rdata = {r_tmo_cnt, r_err_cnt};
         CSR_LAST:   w_csr_rdata = r_last_err;
         CSR_CTRL:   w_csr_rdata = {30'd0, r_fwd_en, 1'b0};
         default:    w_csr_rdata = '0;
      endcase
   end

   assign m_addr     = s_addr[INGR_SLV_ADDR_WIDTH+1:2];
   assign m_wrdata   = s_wrdata;
   assign m_write    = !reset && w_idle && w_fwd && s_write;
   assign m_read     = !reset && w_idle && w_fwd && s_read;
   assign s_waitreq  = reset || !w_idle || (w_fwd && w_cmd && m_waitreq);
   assign s_rdvld    = r_rdvld || w_buf_rsp;
   assign s_rddata   = w_buf_rsp ? m_rddata : r_rddata;
   assign err_cnt_nz = r_err_cnt_nz;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_timer      <= '0;
         r_rdvld      <= 1'b0;
         r_rddata     <= '0;
         r_err_cnt    <= '0;
         r_tmo_cnt    <= '0;
         r_last_err   <= '0;
         r_fwd_en     <= 1'b1;
         r_err_cnt_nz <= 1'b0;
      end else begin
         r_rdvld <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_fwd_rd_acc) begin
                  r_state <= ST_RD_WAIT;
                  r_timer <= TMO_LOAD;
               end else if (s_read && !w_fwd) begin
                  r_state  <= ST_LOCAL_RSP;
                  r_rdvld  <= 1'b1;
                  r_rddata <= w_local ? w_csr_rdata : 32'hBAD0_BAD0;
               end
            end
            ST_RD_WAIT: begin
               if (m_rddvld) begin
                  r_state <= ST_IDLE;
               end else if (w_timeout) begin
                  r_state  <= ST_IDLE;
                  r_rdvld  <= 1'b1;
                  r_rddata <= 32'hFFFF_FFFF;
               end else begin
                  r_timer <= r_timer - TMO_LAST;
               end
            end
            default: r_state <= ST_IDLE;
         endcase

         if (w_clr) begin
            r_err_cnt  <= '0;
            r_tmo_cnt  <= '0;
            r_last_err <= '0;
         end else begin
            if (w_err_acc) begin
               r_last_err <= s_addr;
               if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
            end
            if (w_timeout && (r_tmo_cnt != 16'hFFFF)) r_tmo_cnt <= r_tmo_cnt + 16'd1;
         end

         if (w_ctrl_wr) r_fwd_en <= s_wrdata[1];
         r_err_cnt_nz <= (r_err_cnt != '0) || (r_tmo_cnt != '0);
      end
   end

endmodule

// File: tb/tb_ingr_spis_avmm_router.sv
// Directed bench for ingr_spis_avmm_router with hand-computed expectations (RD_TIMEOUT=16).
module tb_ingr_spis_avmm_router;

   logic        clk;
   logic        reset;
   logic [31:0] s_addr;
   logic        s_write;
   logic        s_read;
   logic [3:0]  s_byteen;
   logic [31:0] s_wrdata;
   logic [31:0] s_rddata;
   logic        s_rdvld;
   logic        s_waitreq;
   logic [8:0]  m_addr;
   logic        m_write;
   logic        m_read;
   logic [31:0] m_wrdata;
   logic [31:0] m_rddata;
   logic        m_rddvld;
   logic        m_waitreq;
   logic        err_cnt_nz;

   int n_total;
   int n_bad;

   ingr_spis_avmm_router #(
      .INGR_SLV_ADDR_WIDTH (9),
      .INGR_SLV_CSR_AWIDTH (8),
      .RD_TIMEOUT          (16),
      .ID_VALUE            (32'h4953_5231)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .s_addr     (s_addr),
      .s_write    (s_write),
      .s_read     (s_read),
      .s_byteen   (s_byteen),
      .s_wrdata   (s_wrdata),
      .s_rddata   (s_rddata),
      .s_rdvld    (s_rdvld),
      .s_waitreq  (s_waitreq),
      .m_addr     (m_addr),
      .m_write    (m_write),
      .m_read     (m_read),
      .m_wrdata   (m_wrdata),
      .m_rddata   (m_rddata),
      .m_rddvld   (m_rddvld),
      .m_waitreq  (m_waitreq),
      .err_cnt_nz (err_cnt_nz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Local or dropped write: accepted in the cycle it is presented
   task automatic wr_short(input string tag, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] data);
      s_addr = addr; s_byteen = be; s_wrdata = data; s_write = 1'b1;
      #1;
      chk({tag, ".waitreq"}, {31'd0, s_waitreq}, 32'd0);
      chk({tag, ".m_write"}, {31'd0, m_write}, 32'd0);
      tick;
      s_write = 1'b0;
      $display("wr  addr=%h be=%h data=%h", addr, be, data);
   endtask

   // Local or dropped read: data one cycle after acceptance
   task automatic rd_short(input string tag, input logic [31:0] addr, input logic [31:0] exp);
      s_addr = addr; s_byteen = 4'hF; s_read = 1'b1;
      #1;
      chk({tag, ".waitreq"}, {31'd0, s_waitreq}, 32'd0);
      chk({tag, ".m_read"}, {31'd0, m_read}, 32'd0);
      tick;
      s_read = 1'b0;
      #1;
      chk({tag, ".rdvld"}, {31'd0, s_rdvld}, 32'd1);
      chk({tag, ".data"}, s_rddata, exp);
      tick;
      chk({tag, ".rdvld_end"}, {31'd0, s_rdvld}, 32'd0);
      $display("rd  addr=%h data=%h", addr, exp);
   endtask

   initial begin
      n_total = 0; n_bad = 0;
      reset = 1'b1;
      s_addr = '0; s_write = 1'b0; s_read = 1'b0; s_byteen = 4'h0; s_wrdata = '0;
      m_rddata = '0; m_rddvld = 1'b0; m_waitreq = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.waitreq", {31'd0, s_waitreq}, 32'd1);
      chk("rst.rdvld", {31'd0, s_rdvld}, 32'd0);
      chk("rst.rddata", s_rddata, 32'd0);
      chk("rst.m_read", {31'd0, m_read}, 32'd0);
      chk("rst.m_write", {31'd0, m_write}, 32'd0);
      chk("rst.nz", {31'd0, err_cnt_nz}, 32'd0);
      reset = 1'b0;
      tick;

      // Forwarded write stalled 3 cycles by the buffer
      s_addr = 32'h400; s_byteen = 4'hF; s_wrdata = 32'h1234_5678; s_write = 1'b1; m_waitreq = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) m_waitreq = 1'b0;
         #1;
         chk("fwr.m_write", {31'd0, m_write}, 32'd1);
         chk("fwr.waitreq", {31'd0, s_waitreq}, (i < 3) ? 32'd1 : 32'd0);
         if (i == 0) begin
            chk("fwr.m_addr", {23'd0, m_addr}, 32'h100);
            chk("fwr.m_wrdata", m_wrdata, 32'h1234_5678);
         end
         tick;
      end
      s_write = 1'b0;
      #1;
      chk("fwr.m_write_end", {31'd0, m_write}, 32'd0);
      $display("fwd wr addr=00000400 data=12345678 stall=3");

      // Forwarded read, buffer answers 5 cycles after acceptance
      s_addr = 32'h404; s_read = 1'b1;
      #1;
      chk("frd.m_read", {31'd0, m_read}, 32'd1);
      chk("frd.m_addr", {23'd0, m_addr}, 32'h101);
      chk("frd.waitreq", {31'd0, s_waitreq}, 32'd0);
      tick;
      s_read = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         if (k == 5) begin
            m_rddvld = 1'b1; m_rddata = 32'hA5A5_0001;
         end
         #1;
         chk("frd.wait_waitreq", {31'd0, s_waitreq}, 32'd1);
         chk("frd.wait_m_read", {31'd0, m_read}, 32'd0);
         chk("frd.rdvld", {31'd0, s_rdvld}, (k == 5) ? 32'd1 : 32'd0);
         if (k == 5) chk("frd.data", s_rddata, 32'hA5A5_0001);
         tick;
      end
      m_rddvld = 1'b0;
      #1;
      chk("frd.rdvld_end", {31'd0, s_rdvld}, 32'd0);
      chk("frd.idle_waitreq", {31'd0, s_waitreq}, 32'd0);
      $display("fwd rd addr=00000404 data=a5a50001 lat=5");

      // Forwarded read that never answers: timeout 17 cycles after acceptance
      s_addr = 32'h408; s_read = 1'b1;
      #1;
      chk("tmo.m_read", {31'd0, m_read}, 32'd1);
      tick;
      s_read = 1'b0;
      for (int k = 1; k <= 17; k++) begin
         #1;
         chk("tmo.rdvld", {31'd0, s_rdvld}, (k == 17) ? 32'd1 : 32'd0);
         if (k == 17) chk("tmo.data", s_rddata, 32'hFFFF_FFFF);
         tick;
      end
      m_rddvld = 1'b1; m_rddata = 32'h1111_2222;
      #1;
      chk("tmo.stray_rdvld", {31'd0, s_rdvld}, 32'd0);
      chk("tmo.nz", {31'd0, err_cnt_nz}, 32'd1);
      tick;
      m_rddvld = 1'b0;
      $display("fwd rd addr=00000408 timeout data=ffffffff");
      rd_short("tmo.status", 32'h4, 32'h0001_0000);

      // Partial-byte write to buffer space is dropped and recorded
      wr_short("bad_be", 32'h400, 4'h3, 32'hDEAD_BEEF);
      rd_short("bad_be.last", 32'h8, 32'h0000_0400);
      rd_short("bad_be.status", 32'h4, 32'h0001_0001);
      chk("bad_be.nz", {31'd0, err_cnt_nz}, 32'd1);

      // Forwarding disabled: buffer read becomes an error read
      wr_short("ctrl0", 32'hC, 4'hF, 32'h0);
      rd_short("ctrl0.rb", 32'hC, 32'h0);
      rd_short("nofwd", 32'h400, 32'hBAD0_BAD0);
      rd_short("nofwd.status", 32'h4, 32'h0001_0002);
      wr_short("ctrl3", 32'hC, 4'hF, 32'h3);
      rd_short("ctrl3.status", 32'h4, 32'h0);
      rd_short("ctrl3.rb", 32'hC, 32'h2);
      rd_short("ctrl3.last", 32'h8, 32'h0);
      chk("ctrl3.nz", {31'd0, err_cnt_nz}, 32'd0);
      rd_short("unlisted", 32'h10, 32'h0);

      // ID read, then reset in the middle of a forwarded read
      wr_short("pre_rst_err", 32'h404, 4'h1, 32'h0);
      rd_short("id", 32'h0, 32'h4953_5231);
      chk("pre_rst.nz", {31'd0, err_cnt_nz}, 32'd1);
      s_addr = 32'h40C; s_byteen = 4'hF; s_read = 1'b1;
      tick;
      s_read = 1'b0;
      tick;
      reset = 1'b1;
      #1;
      chk("rst2.waitreq", {31'd0, s_waitreq}, 32'd1);
      chk("rst2.rdvld", {31'd0, s_rdvld}, 32'd0);
      chk("rst2.rddata", s_rddata, 32'd0);
      chk("rst2.nz", {31'd0, err_cnt_nz}, 32'd0);
      chk("rst2.m_read", {31'd0, m_read}, 32'd0);
      tick;
      reset = 1'b0;
      m_rddvld = 1'b1; m_rddata = 32'h3333_4444;
      #1;
      chk("rst2.stray_rdvld", {31'd0, s_rdvld}, 32'd0);
      chk("rst2.idle_waitreq", {31'd0, s_waitreq}, 32'd0);
      tick;
      m_rddvld = 1'b0;
      $display("reset during RD_WAIT addr=0000040c");
      rd_short("rst2.status", 32'h4, 32'h0);
      rd_short("rst2.ctrl", 32'hC, 32'h2);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/ingr_spis_avmm_router.md
# ingr_spis_avmm_router

Address router and response guard between the ingress SPI-slave Avalon packets-to-master bridge and the ingress AVMM slave port of the MCTP PCIe-VDM buffer. Qualified full-word accesses are forwarded to the buffer. Accesses to the low CSR window hit a small local register block. Malformed accesses are dropped and counted. A bounded-latency read guarantee stops a stalled buffer from hanging the SPI bridge.

## Interface
Parameters:
- INGR_SLV_ADDR_WIDTH, 9, word-address width of the buffer port.
- INGR_SLV_CSR_AWIDTH, 8, byte-address width of the local CSR window; addr[31:INGR_SLV_CSR_AWIDTH]==0 selects local.
- RD_TIMEOUT, 1023, cycles after read acceptance before a forwarded read is abandoned (>=2).
- ID_VALUE, 32'h4953_5231, value of the ID register.

Ports (clock and reset first):
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- s_addr  in  32  byte address from the SPI bridge.
- s_write / s_read  in  1  command strobes (never both).
- s_byteen  in  4  byte enables.
- s_wrdata  in  32  write data.
- s_rddata  out  32  read data.
- s_rdvld  out  1  read data valid.
- s_waitreq  out  1  stall.
- m_addr  out  INGR_SLV_ADDR_WIDTH  = s_addr[INGR_SLV_ADDR_WIDTH+1:2].
- m_write / m_read  out  1  forwarded strobes.
- m_wrdata  out  32  = s_wrdata.
- m_rddata  in  32  buffer read data.
- m_rddvld  in  1  buffer read valid.
- m_waitreq  in  1  buffer stall.
- err_cnt_nz  out  1  high while either counter is non-zero.

## Operation
Access classes, decoded combinationally in IDLE:
- LOCAL: upper address bits zero.
- FWD: upper bits non-zero, byteen==4'hF, CTRL.fwd_en=1.
- ERR: all other accesses.

FSM states: IDLE, RD_WAIT, LOCAL_RSP.
- IDLE, FWD write: m_write=s_write, s_waitreq=m_waitreq. The write completes on the cycle m_waitreq=0. Stay in IDLE.
- IDLE, FWD read: m_read=1, s_waitreq=m_waitreq. On acceptance, load timer=RD_TIMEOUT and go to RD_WAIT.
- RD_WAIT: s_waitreq=1, m_read=0.
  - m_rddvld=1: s_rdvld=1 and s_rddata=m_rddata in the same cycle; go to IDLE.
  - Otherwise the timer decrements. At 0: registered s_rdvld=1, s_rddata=32'hFFFF_FFFF, tmo_cnt++, go to IDLE.
  - If m_rddvld and expiry coincide, m_rddvld wins and there is no timeout count.
- IDLE, LOCAL or ERR: s_waitreq=0, so the command is accepted in 1 cycle.
  - Reads go to LOCAL_RSP, which lasts 1 cycle with s_waitreq=1, then return to IDLE.
  - LOCAL_RSP drives s_rdvld=1 with the register value. ERR reads return 32'hBAD0_BAD0.
  - Writes stay in IDLE.
  - ERR reads and writes: err_cnt++, LAST_ERR<=s_addr.
- m_rddvld outside RD_WAIT (a late response after timeout) is discarded and never reaches s_rdvld.

CSR map (byte offset within the local window; unlisted offsets read 0, ignore writes):
- 0x0 ID: RO, ID_VALUE.
- 0x4 STATUS: RO, [15:0] err_cnt, [31:16] tmo_cnt. Both counters saturate at 16'hFFFF.
- 0x8 LAST_ERR: RO, reset 0.
- 0xC CTRL: bit0 clr (write 1 clears both counters and LAST_ERR, self-clearing, reads 0); bit1 fwd_en (RW, reset 1).
- Local writes with byteen!=4'hF are ignored and not counted.
- If a clear and an increment occur in the same cycle, the clear wins.

## Timing
- Reset values: s_rdvld=0, s_rddata=0, m_read=0, m_write=0, state=IDLE, counters=0, LAST_ERR=0, fwd_en=1, err_cnt_nz=0.
- s_waitreq=1 while reset is asserted.
- At most one read outstanding. No new command is accepted outside IDLE.
- Latencies:
  - Local/ERR write: 1 cycle.
  - Local/ERR read: s_rdvld 1 cycle after acceptance.
  - Forwarded read: buffer latency plus 0 cycles.
  - Timeout: s_rdvld exactly RD_TIMEOUT+1 cycles after acceptance.
- Reset mid-RD_WAIT: return to IDLE immediately. No s_rdvld is produced for the aborted read.
- err_cnt_nz is registered and updates 1 cycle after a counter change.

## Test plan
- Write 0x1234_5678 to s_addr 0x400, byteen F, with m_waitreq held 3 cycles: m_write high for 4 cycles, m_addr=0x100, s_waitreq releases on the 4th cycle.
- Read s_addr 0x404 with the buffer returning 0xA5A5_0001 after 5 cycles: s_rdvld and data arrive in that same cycle, and s_waitreq stays 1 throughout RD_WAIT.
- Forwarded read with no response, RD_TIMEOUT=16: s_rdvld with 0xFFFF_FFFF 17 cycles after acceptance, STATUS=0x0001_0000. A subsequent stray m_rddvld is dropped.
- Write byteen 4'h3 to 0x400, then read 0x8: no m_write is issued, the read returns 0x0000_0400, STATUS[15:0]=1, err_cnt_nz=1.
- Write 0x0 to CTRL (fwd_en=0), then read 0x400: returns 0xBAD0_BAD0 with no m_read. Then write CTRL=0x3: counters clear and fwd_en is restored.
- Read 0x0: returns ID_VALUE 1 cycle after acceptance. Assert reset during RD_WAIT: no s_rdvld, all outputs return to reset values.
